// File: rtl/random_range_gen.sv
// On-demand uniform draws in a runtime [min_val, max_val] range for game logic.
// A free-running Galois LFSR is stirred by an entropy counter on each rising edge of rise.
module random_range_gen #(
    parameter int                   DATA_BITS = 10,
    parameter int                   LFSR_BITS = 16,
    parameter logic [LFSR_BITS-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_BITS-1:0] SEED      = 16'hACE1,
    parameter int                   MAX_TRIES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 rise,
    input  logic                 seed_load,
    input  logic [LFSR_BITS-1:0] seed,
    input  logic [DATA_BITS-1:0] min_val,
    input  logic [DATA_BITS-1:0] max_val,
    output logic                 busy,
    output logic                 valid,
    output logic [DATA_BITS-1:0] dout,
    output logic                 fallback
);

    localparam int TRY_BITS = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_BITS-1:0] LAST_TRY = TRY_BITS'(MAX_TRIES - 1);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t               state;
    logic [LFSR_BITS-1:0] lfsr;
    logic [LFSR_BITS-1:0] ent_cnt;
    logic                 rise_d;
    logic [LFSR_BITS-1:0] lfsr_step;
    logic [LFSR_BITS-1:0] lfsr_mixed;
    logic [LFSR_BITS-1:0] lfsr_next;
    logic [DATA_BITS-1:0] lo_r;
    logic [DATA_BITS-1:0] span_r;
    logic [DATA_BITS-1:0] mask;
    logic [DATA_BITS-1:0] cand;
    logic [TRY_BITS-1:0]  tries;

    // An all-zero LFSR would lock up, so both the seed path and the entropy mix fall back to SEED.
    always_comb begin
        lfsr_step  = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
        lfsr_mixed = lfsr_step ^ ent_cnt;
        if (seed_load)
            lfsr_next = (seed == '0) ? SEED : seed;
        else if (rise && !rise_d)
            lfsr_next = (lfsr_mixed == '0) ? SEED : lfsr_mixed;
        else
            lfsr_next = lfsr_step;
    end

    // Smearing the span's top bit downward gives the smallest all-ones mask covering it.
    always_comb begin
        mask = span_r;
        for (int i = 0; i < DATA_BITS; i++)
            mask = mask | (mask >> 1);
        cand = lfsr[DATA_BITS-1:0] & mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr     <= SEED;
            ent_cnt  <= '0;
            rise_d   <= 1'b0;
            state    <= IDLE;
            busy     <= 1'b0;
            valid    <= 1'b0;
            dout     <= '0;
            fallback <= 1'b0;
            tries    <= '0;
            lo_r     <= '0;
            span_r   <= '0;
        end else begin
            lfsr    <= lfsr_next;
            ent_cnt <= ent_cnt + 1'b1;
            rise_d  <= rise;
            valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (min_val <= max_val) begin
                            lo_r   <= min_val;
                            span_r <= max_val - min_val;
                        end else begin
                            lo_r   <= max_val;
                            span_r <= min_val - max_val;
                        end
                        tries <= '0;
                        busy  <= 1'b1;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (cand <= span_r) begin
                        dout     <= lo_r + cand;
                        fallback <= 1'b0;
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (tries == LAST_TRY) begin
                        // Halving a rejected candidate always lands inside the span.
                        dout     <= lo_r + (cand >> 1);
                        fallback <= 1'b1;
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
